// File: rtl/miyamii_alu_pkg.sv
// -----------------------------------------------------------------------------
// miyamii_alu_pkg
//   Shared definitions for the Miyamii multi-digit ALU:
//     - DIGIT_W    : width of one processed digit (4 bits)
//     - OP_*       : operation codes (4-bit)
//     - state_t    : FSM state encoding of digit_serial_alu
//     - idx_width(): width of a digit index counter for a given digit count
// -----------------------------------------------------------------------------
package miyamii_alu_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_BCD_ADD = 4'd2;
    localparam logic [3:0] OP_BCD_SUB = 4'd3;
    localparam logic [3:0] OP_AND     = 4'd4;
    localparam logic [3:0] OP_OR      = 4'd5;
    localparam logic [3:0] OP_XOR     = 4'd6;
    localparam logic [3:0] OP_RAL     = 4'd7;
    localparam logic [3:0] OP_RAR     = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-digit build still needs a 1-bit counter.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// -----------------------------------------------------------------------------
// alu_digit_slice
//   Combinational one-digit ALU step. Computes one result digit and the carry
//   passed on to the next digit processed.
//   Ports:
//     ai, bi  in  DIGIT_W  operand digits
//     c       in  1        incoming carry (carry = 1 means "no borrow" for subs)
//     op      in  4        operation code (OP_*)
//     digit   out DIGIT_W  result digit
//     c_next  out 1        outgoing carry
// -----------------------------------------------------------------------------
module alu_digit_slice
    import miyamii_alu_pkg::*;
(
    input  logic [DIGIT_W-1:0] ai,
    input  logic [DIGIT_W-1:0] bi,
    input  logic               c,
    input  logic [3:0]         op,
    output logic [DIGIT_W-1:0] digit,
    output logic               c_next
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statements can infer a latch.
    always_comb begin
        // Subtraction reuses the adder: binary uses ~b, BCD uses the nines'
        // complement (wrapping mod 16 for non-BCD digits).
        b_eff = bi;
        case (op)
            OP_SUB:     b_eff = ~bi;
            OP_BCD_SUB: b_eff = DIGIT_W'(9) - bi;
            default:    b_eff = bi;
        endcase

        sum = {1'b0, ai} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, c};

        digit  = '0;
        c_next = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                digit  = sum[DIGIT_W-1:0];
                c_next = sum[DIGIT_W];
            end
            OP_BCD_ADD, OP_BCD_SUB: begin
                // Decimal adjust: adding 6 and keeping the low nibble is the
                // same as (s + 6)[3:0] for every 5-bit s, valid BCD or not.
                if (sum > (DIGIT_W+1)'(9)) begin
                    digit  = sum[DIGIT_W-1:0] + DIGIT_W'(6);
                    c_next = 1'b1;
                end else begin
                    digit  = sum[DIGIT_W-1:0];
                    c_next = 1'b0;
                end
            end
            OP_AND: begin
                digit  = ai & bi;
                c_next = c;
            end
            OP_OR: begin
                digit  = ai | bi;
                c_next = c;
            end
            OP_XOR: begin
                digit  = ai ^ bi;
                c_next = c;
            end
            OP_RAL: begin
                digit  = {ai[DIGIT_W-2:0], c};
                c_next = ai[DIGIT_W-1];
            end
            OP_RAR: begin
                digit  = {c, ai[DIGIT_W-1:1]};
                c_next = ai[0];
            end
            default: begin
                // Undefined codes produce zero and clear the carry.
                digit  = '0;
                c_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/digit_serial_alu.sv
// -----------------------------------------------------------------------------
// digit_serial_alu
//   Multi-digit ALU processing one 4-bit digit per clock with carry chained
//   between digits. Binary/BCD add and subtract, AND/OR/XOR, and rotate left/
//   right through carry over a DIGITS*4-bit word. Valid/ready on both sides.
//   Latency from accept edge to res_valid is exactly DIGITS cycles.
//   Parameters:
//     DIGITS     number of 4-bit digits (1..16)
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     cmd_valid  in   command offered
//     cmd_ready  out  idle, command will be accepted (registered)
//     op         in   operation code, sampled on accept
//     a, b       in   operands, sampled on accept
//     carry_in   in   initial carry / no-borrow, sampled on accept
//     res_valid  out  result available (registered)
//     res_ready  in   consumer takes result
//     result     out  result word (registered)
//     carry_out  out  final carry (registered)
//     zero       out  result == 0 (registered)
// -----------------------------------------------------------------------------
module digit_serial_alu
    import miyamii_alu_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  op,
    input  logic [DIGIT_W*DIGITS-1:0]   a,
    input  logic [DIGIT_W*DIGITS-1:0]   b,
    input  logic                        carry_in,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DIGIT_W*DIGITS-1:0]   result,
    output logic                        carry_out,
    output logic                        zero
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             state;
    logic [3:0]         op_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               c_q;
    logic [IDX_W-1:0]   cnt;      // digits completed so far in this command

    logic [IDX_W-1:0]   pos;      // digit position handled this cycle
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] slice_digit;
    logic               slice_c;
    logic [W-1:0]       result_next;

    // RAR must see the MSB digit first so its low bit can ripple downwards;
    // every other op walks LSB first.
    always_comb begin
        pos   = (op_q == OP_RAR) ? (LAST_IDX - cnt) : cnt;
        a_dig = a_q[pos*DIGIT_W +: DIGIT_W];
        b_dig = b_q[pos*DIGIT_W +: DIGIT_W];

        result_next = result;
        result_next[pos*DIGIT_W +: DIGIT_W] = slice_digit;
    end

    alu_digit_slice u_slice (
        .ai     (a_dig),
        .bi     (b_dig),
        .c      (c_q),
        .op     (op_q),
        .digit  (slice_digit),
        .c_next (slice_c)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op;
                        a_q       <= a;
                        b_q       <= b;
                        c_q       <= carry_in;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        state     <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    result <= result_next;
                    c_q    <= slice_c;
                    if (cnt == LAST_IDX) begin
                        // Flags come from the fully assembled word, including
                        // the digit completing on this edge.
                        carry_out <= slice_c;
                        zero      <= (result_next == '0);
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end

                ST_DONE: begin
                    // cmd_ready only rises after this edge, so a new command
                    // can never be accepted on the consume edge.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
